// File: rtl/dvp_tx.sv
// DVP (OV5640-style) transmitter: serializes RGB565 pixels from a latency-1 FIFO or an
// internal colour-bar generator onto an 8-bit bus with pclk = sys_clk/2.
module dvp_tx #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BACK   = 16,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tx_en,
    input  logic        pat_sel,
    output logic        pix_rd_en,
    input  logic [15:0] pix_data,
    input  logic        fifo_empty,
    output logic        dvp_pclk,
    output logic        dvp_href,
    output logic        dvp_vsync,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underrun
);

    localparam int unsigned HTotal = H_BLANK + 2 * H_ACTIVE;
    localparam int unsigned VTotal = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW     = $clog2(HTotal + 1);
    localparam int unsigned VW     = $clog2(VTotal + 1);

    localparam logic [HW-1:0] HLast    = HW'(HTotal - 1);
    localparam logic [HW-1:0] HBlank   = HW'(H_BLANK);
    localparam logic [HW-1:0] HOne     = HW'(1);
    localparam logic [HW-1:0] BarW     = HW'(H_ACTIVE / 8);
    localparam logic [VW-1:0] VLast    = VW'(VTotal - 1);
    localparam logic [VW-1:0] VOne     = VW'(1);
    localparam logic [VW-1:0] VSyncEnd = VW'(V_SYNC);
    localparam logic [VW-1:0] VActBeg  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] VActEnd  = VW'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic          ph_q, ph_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          href_q, href_d;
    logic          vsync_q, vsync_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    low_q, low_d;
    logic          pat_q, pat_d;
    logic          rd_q, rd_d;
    logic          underrun_q, underrun_d;

    logic          running, frame_end, line_act, rd_slot;
    logic [HW-1:0] h_inc, inc_off;
    logic [HW-1:0] h_nxt, off_nxt, pix_x;
    logic [VW-1:0] v_nxt;
    logic          act_nxt;
    logic [2:0]    bar_idx;
    logic [15:0]   bar_pix, pix_nxt;

    assign running   = (state_q == StRun);
    assign frame_end = running && (h_cnt_q == HLast) && (v_cnt_q == VLast);
    assign line_act  = (v_cnt_q >= VActBeg) && (v_cnt_q < VActEnd);
    assign h_inc     = h_cnt_q + HOne;
    assign inc_off   = h_inc - HBlank;

    // Read slot: ph=0 of the byte period just before a high byte on an active line.
    assign rd_slot   = running && !ph_q && !pat_q && line_act && (h_cnt_q != HLast) &&
                       (h_inc >= HBlank) && !inc_off[0];
    assign pix_rd_en = rd_slot && !fifo_empty;

    assign dvp_pclk   = ph_q;
    assign dvp_href   = href_q;
    assign dvp_vsync  = vsync_q;
    assign dvp_data   = data_q;
    assign frame_done = frame_end && ph_q;
    assign underrun   = underrun_q;

    always_comb begin
        state_d    = state_q;
        ph_d       = ~ph_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        href_d     = href_q;
        vsync_d    = vsync_q;
        data_d     = data_q;
        low_d      = low_q;
        pat_d      = pat_q;
        rd_d       = pix_rd_en;
        underrun_d = underrun_q | (rd_slot & fifo_empty);
        h_nxt      = '0;
        v_nxt      = '0;
        off_nxt    = '0;
        pix_x      = '0;
        act_nxt    = 1'b0;
        bar_idx    = '0;
        bar_pix    = '0;
        pix_nxt    = '0;

        // Every position/output update happens on the edge entering ph=0.
        if (ph_q) begin
            if ((!running && !tx_en) || (frame_end && !tx_en)) begin
                state_d = StIdle;
                h_cnt_d = '0;
                v_cnt_d = '0;
                href_d  = 1'b0;
                vsync_d = 1'b0;
                data_d  = '0;
            end else begin
                state_d = StRun;
                if (!running || frame_end) begin
                    h_nxt = '0;
                    v_nxt = '0;
                    pat_d = pat_sel;
                end else if (h_cnt_q == HLast) begin
                    h_nxt = '0;
                    v_nxt = v_cnt_q + VOne;
                end else begin
                    h_nxt = h_inc;
                    v_nxt = v_cnt_q;
                end

                off_nxt = h_nxt - HBlank;
                pix_x   = {1'b0, off_nxt[HW-1:1]};
                bar_idx = 3'(pix_x / BarW);
                case (bar_idx)
                    3'd0:    bar_pix = 16'hFFFF;
                    3'd1:    bar_pix = 16'hFFE0;
                    3'd2:    bar_pix = 16'h07FF;
                    3'd3:    bar_pix = 16'h07E0;
                    3'd4:    bar_pix = 16'hF81F;
                    3'd5:    bar_pix = 16'hF800;
                    3'd6:    bar_pix = 16'h001F;
                    default: bar_pix = 16'h0000;
                endcase
                // A missed read (FIFO empty) leaves rd_q low, so the pixel goes out as zero.
                pix_nxt = pat_d ? bar_pix : (rd_q ? pix_data : 16'h0000);

                act_nxt = (v_nxt >= VActBeg) && (v_nxt < VActEnd) && (h_nxt >= HBlank);
                h_cnt_d = h_nxt;
                v_cnt_d = v_nxt;
                vsync_d = (v_nxt < VSyncEnd);
                href_d  = act_nxt;
                if (!act_nxt) begin
                    data_d = '0;
                end else if (!off_nxt[0]) begin
                    data_d = pix_nxt[15:8];
                    low_d  = pix_nxt[7:0];
                end else begin
                    data_d = low_q;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            ph_q       <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            data_q     <= '0;
            low_q      <= '0;
            pat_q      <= 1'b0;
            rd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            href_q     <= href_d;
            vsync_q    <= vsync_d;
            data_q     <= data_d;
            low_q      <= low_d;
            pat_q      <= pat_d;
            rd_q       <= rd_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_dvp_tx.sv
// Directed bench for dvp_tx on a tiny 40-cycle-line, 200-cycle-frame raster,
// with a small latency-1 FIFO model feeding pixel words.
module tb_dvp_tx;

    localparam int unsigned H_ACTIVE = 8;
    localparam int unsigned H_BLANK  = 4;
    localparam int unsigned V_SYNC   = 1;
    localparam int unsigned V_BACK   = 1;
    localparam int unsigned V_ACTIVE = 2;
    localparam int unsigned V_FRONT  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_en = 1'b0;
    logic        pat_sel = 1'b0;
    logic        pix_rd_en;
    logic [15:0] pix_data = 16'h0000;
    logic        fifo_empty;
    logic        dvp_pclk, dvp_href, dvp_vsync, frame_done, underrun;
    logic [7:0]  dvp_data;

    logic [15:0] fifo_mem [64];
    int          fifo_ptr = 0;
    int          fifo_lim = 0;

    logic        r_href [200];
    logic        r_vsync [200];
    logic        r_pclk [200];
    logic        r_rd [200];
    logic        r_fd [200];
    logic        r_ur [200];
    logic [7:0]  r_data [200];
    logic [7:0]  bar_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                     8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    int checks = 0;
    int failures = 0;

    dvp_tx #(
        .H_ACTIVE(H_ACTIVE),
        .H_BLANK (H_BLANK),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_ACTIVE(V_ACTIVE),
        .V_FRONT (V_FRONT)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .tx_en     (tx_en),
        .pat_sel   (pat_sel),
        .pix_rd_en (pix_rd_en),
        .pix_data  (pix_data),
        .fifo_empty(fifo_empty),
        .dvp_pclk  (dvp_pclk),
        .dvp_href  (dvp_href),
        .dvp_vsync (dvp_vsync),
        .dvp_data  (dvp_data),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fifo_ptr >= fifo_lim);

    always @(posedge clk) begin
        if (pix_rd_en && !fifo_empty) begin
            pix_data <= fifo_mem[fifo_ptr];
            fifo_ptr <= fifo_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records the current negedge sample, then steps to the next negedge.
    task automatic cap(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            r_href[start+i]  = dvp_href;
            r_vsync[start+i] = dvp_vsync;
            r_pclk[start+i]  = dvp_pclk;
            r_rd[start+i]    = pix_rd_en;
            r_fd[start+i]    = frame_done;
            r_ur[start+i]    = underrun;
            r_data[start+i]  = dvp_data;
            @(negedge clk);
        end
    endtask

    task automatic wait_start(input string tag);
        int i;
        i = 0;
        while (!dvp_vsync && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {31'd0, dvp_vsync}, 32'd1);
    endtask

    task automatic load_fifo(input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) fifo_mem[fifo_ptr+k] = base + 16'(k);
        fifo_lim = fifo_ptr + n;
    endtask

    task automatic check_frame(input string tag);
        int nv, nh, nf;
        nv = 0; nh = 0; nf = 0;
        for (int i = 0; i < 200; i++) begin
            nv += int'(r_vsync[i]);
            nh += int'(r_href[i]);
            nf += int'(r_fd[i]);
        end
        chk({tag, "_vsync_cnt"}, nv, 40);
        chk({tag, "_vsync_first"}, {31'd0, r_vsync[0]}, 32'd1);
        chk({tag, "_vsync_end"}, {31'd0, r_vsync[40]}, 32'd0);
        chk({tag, "_href_cnt"}, nh, 64);
        chk({tag, "_fd_cnt"}, nf, 1);
        chk({tag, "_fd_199"}, {31'd0, r_fd[199]}, 32'd1);
    endtask

    task automatic count_rd(input string tag, input int exp);
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) n += int'(r_rd[i]);
        chk(tag, n, exp);
    endtask

    initial begin
        int c, nz, ntog;
        logic [15:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pclk", {31'd0, dvp_pclk}, 32'd0);
        chk("rst_href", {31'd0, dvp_href}, 32'd0);
        chk("rst_vsync", {31'd0, dvp_vsync}, 32'd0);
        chk("rst_data", {24'd0, dvp_data}, 32'd0);
        chk("rst_rd", {31'd0, pix_rd_en}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_ur", {31'd0, underrun}, 32'd0);
        rst_n = 1'b1;
        cap(0, 6);
        chk("idle_pclk_tog", {31'd0, r_pclk[2] ^ r_pclk[3]}, 32'd1);
        chk("idle_vsync", {31'd0, r_vsync[5]}, 32'd0);

        // Frame A: colour bars
        pat_sel = 1'b1;
        tx_en = 1'b1;
        wait_start("start_a");
        pat_sel = 1'b0;
        load_fifo(16'h1234, 16);
        cap(0, 200);
        check_frame("a");
        chk("a_pclk0", {31'd0, r_pclk[0]}, 32'd0);
        chk("a_pclk1", {31'd0, r_pclk[1]}, 32'd1);
        chk("a_href87", {31'd0, r_href[87]}, 32'd0);
        chk("a_href88", {31'd0, r_href[88]}, 32'd1);
        chk("a_href120", {31'd0, r_href[120]}, 32'd0);
        chk("a_href128", {31'd0, r_href[128]}, 32'd1);
        count_rd("a_rd_cnt", 0);
        for (int l = 0; l < 2; l++)
            for (int b = 0; b < 16; b++)
                chk("a_bar_byte", {24'd0, r_data[88 + 40*l + 2*b]}, {24'd0, bar_bytes[b]});

        // Frame B: 16 FIFO words, back-to-back with frame A
        cap(0, 180);
        load_fifo(16'hA5C0, 3);
        cap(180, 20);
        check_frame("b");
        count_rd("b_rd_cnt", 16);
        for (int k = 0; k < 16; k++) begin
            c = 88 + 40*(k/8) + 4*(k%8);
            w = 16'h1234 + 16'(k);
            chk("b_rd_slot", {31'd0, r_rd[c-2]}, 32'd1);
            chk("b_hi", {24'd0, r_data[c]}, {24'd0, w[15:8]});
            chk("b_lo", {24'd0, r_data[c+2]}, {24'd0, w[7:0]});
        end
        chk("b_ur", {31'd0, r_ur[199]}, 32'd0);

        // Frame C: only 3 words available
        cap(0, 200);
        check_frame("c");
        count_rd("c_rd_cnt", 3);
        for (int k = 0; k < 16; k++) begin
            c = 88 + 40*(k/8) + 4*(k%8);
            w = (k < 3) ? 16'hA5C0 + 16'(k) : 16'h0000;
            chk("c_hi", {24'd0, r_data[c]}, {24'd0, w[15:8]});
            chk("c_lo", {24'd0, r_data[c+2]}, {24'd0, w[7:0]});
        end
        chk("c_ur98", {31'd0, r_ur[98]}, 32'd0);
        chk("c_ur99", {31'd0, r_ur[99]}, 32'd1);
        chk("c_ur199", {31'd0, r_ur[199]}, 32'd1);

        // Frame D: tx_en dropped mid-frame, frame still completes
        cap(0, 100);
        tx_en = 1'b0;
        cap(100, 100);
        check_frame("d");
        cap(0, 20);
        nz = 0;
        ntog = 0;
        for (int i = 0; i < 20; i++) begin
            nz += int'(r_href[i]) + int'(r_vsync[i]) + int'(r_fd[i]) + int'(r_data[i] != 8'h00);
            if (i < 19) ntog += int'(r_pclk[i] != r_pclk[i+1]);
        end
        chk("idle_quiet", nz, 0);
        chk("idle_pclk_toggles", ntog, 19);
        chk("idle_ur_sticky", {31'd0, r_ur[0]}, 32'd1);

        // Reset during an active line
        tx_en = 1'b1;
        wait_start("start_e");
        repeat (90) @(negedge clk);
        chk("e_href_active", {31'd0, dvp_href}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("e_rst_href", {31'd0, dvp_href}, 32'd0);
        chk("e_rst_vsync", {31'd0, dvp_vsync}, 32'd0);
        chk("e_rst_data", {24'd0, dvp_data}, 32'd0);
        chk("e_rst_pclk", {31'd0, dvp_pclk}, 32'd0);
        chk("e_rst_ur", {31'd0, underrun}, 32'd0);
        pat_sel = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_start("start_f");
        chk("f_href0", {31'd0, dvp_href}, 32'd0);
        chk("f_pclk0", {31'd0, dvp_pclk}, 32'd0);
        cap(0, 200);
        check_frame("f");
        chk("f_ur", {31'd0, r_ur[199]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
